// File: rtl/cmp_pkg.sv
// Shared types for the serial comparator: FSM state encoding and RV32I branch funct3 codes.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  // Funct3 codes 010/011 are not branches and never report taken.
  function automatic logic branch_taken(input logic [2:0] mode, input logic eq,
                                        input logic lt_s, input logic lt_u);
    logic t;
    t = 1'b0;
    case (mode)
      BEQ:     t = eq;
      BNE:     t = !eq;
      BLT:     t = lt_s;
      BGE:     t = !lt_s;
      BLTU:    t = lt_u;
      BGEU:    t = !lt_u;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/digit_compare.sv
// Combinational magnitude compare of one DIGIT-bit slice pair.
module digit_compare #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             slice_lt,
  output logic             slice_eq
);

  assign slice_lt = (a_i < b_i);
  assign slice_eq = (a_i == b_i);

endmodule

// File: rtl/serial_comparator.sv
// Digit-serial signed/unsigned comparator with branch-taken decode, MSB slice first.
// Optional CMP_EARLY_EXIT_EN finishes on the first differing slice instead of after all N slices.
module serial_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt_u,
  output logic             eq_u,
  output logic             lt_u,
  output logic             gt_s,
  output logic             eq_s,
  output logic             lt_s,
  output logic             taken
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (WIDTH % DIGIT != 0) begin : g_bad_cfg
    $error("serial_comparator: WIDTH must be a multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             ltu_q, ltu_d;
  logic             gtu_q, gtu_d;
  logic [WIDTH-1:0] rs1_q, rs1_d;
  logic [WIDTH-1:0] rs2_q, rs2_d;
  logic [2:0]       mode_q, mode_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;

  logic slice_lt;
  logic slice_eq;

  // Operands shift left each BUSY cycle, so the slice under test is always the top one.
  digit_compare #(.DIGIT(DIGIT)) u_digit (
    .a_i      (rs1_q[WIDTH-1 -: DIGIT]),
    .b_i      (rs2_q[WIDTH-1 -: DIGIT]),
    .slice_lt (slice_lt),
    .slice_eq (slice_eq)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    ltu_d     = ltu_q;
    gtu_d     = gtu_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    mode_d    = mode_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rs1_d     = rs1;
          rs2_d     = rs2;
          mode_d    = mode;
          s1_d      = rs1[WIDTH-1];
          s2_d      = rs2[WIDTH-1];
          cnt_d     = '0;
          decided_d = 1'b0;
          ltu_d     = 1'b0;
          gtu_d     = 1'b0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        rs1_d = rs1_q << DIGIT;
        rs2_d = rs2_q << DIGIT;
        cnt_d = cnt_q + 1'b1;
        if (!decided_q && !slice_eq) begin
          decided_d = 1'b1;
          ltu_d     = slice_lt;
          gtu_d     = !slice_lt;
`ifdef CMP_EARLY_EXIT_EN
          state_d   = DONE;
`endif
        end
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      ltu_q     <= 1'b0;
      gtu_q     <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      mode_q    <= '0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      ltu_q     <= ltu_d;
      gtu_q     <= gtu_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      mode_q    <= mode_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
    end
  end

  // With differing signs the negative operand is the smaller one regardless of magnitude.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    gt_u      = 1'b0;
    eq_u      = 1'b0;
    lt_u      = 1'b0;
    gt_s      = 1'b0;
    eq_s      = 1'b0;
    lt_s      = 1'b0;
    taken     = 1'b0;
    if (state_q == DONE) begin
      gt_u  = gtu_q;
      lt_u  = ltu_q;
      eq_u  = !decided_q;
      eq_s  = !decided_q;
      gt_s  = (s1_q == s2_q) ? gtu_q : s2_q;
      lt_s  = (s1_q == s2_q) ? ltu_q : s1_q;
      taken = branch_taken(mode_q, !decided_q, lt_s, ltu_q);
    end
  end

endmodule

// File: tb/tb_serial_comparator.sv
// Scoreboard bench for serial_comparator (WIDTH=32, DIGIT=4); honours CMP_EARLY_EXIT_EN if defined.
module tb_serial_comparator;

  localparam int WIDTH = 32;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [2:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic        gt_u, eq_u, lt_u, gt_s, eq_s, lt_s, taken;
  logic [6:0]  flags_w;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_bad  = 0;

  typedef struct {
    logic [6:0] flags;
    int         lat;
  } exp_t;
  exp_t sb[$];

  serial_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gt_u      (gt_u),
    .eq_u      (eq_u),
    .lt_u      (lt_u),
    .gt_s      (gt_s),
    .eq_s      (eq_s),
    .lt_s      (lt_s),
    .taken     (taken)
  );

  assign flags_w = {gt_u, eq_u, lt_u, gt_s, eq_s, lt_s, taken};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {gt_u, eq_u, lt_u, gt_s, eq_s, lt_s, taken} from whole-word arithmetic.
  function automatic logic [6:0] model(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] m);
    logic ltu, gtu, eq, lts, gts, tk;
    ltu = (a < b);
    gtu = (a > b);
    eq  = (a == b);
    lts = ($signed(a) < $signed(b));
    gts = ($signed(a) > $signed(b));
    case (m)
      3'b000:  tk = eq;
      3'b001:  tk = !eq;
      3'b100:  tk = lts;
      3'b101:  tk = !lts;
      3'b110:  tk = ltu;
      3'b111:  tk = !ltu;
      default: tk = 1'b0;
    endcase
    return {gtu, eq, ltu, gts, eq, lts, tk};
  endfunction

  // Cycles from the accept cycle to the first out_valid cycle.
  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef CMP_EARLY_EXIT_EN
    for (int i = 0; i < N; i++) begin
      if (a[WIDTH-1-i*DIGIT -: DIGIT] != b[WIDTH-1-i*DIGIT -: DIGIT]) return i + 2;
    end
`else
    if (a == b) return N + 1;
`endif
    return N + 1;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                        input int hold);
    exp_t e;
    int   acc;
    int   t;
    logic [6:0] snap;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    rs1 = a; rs2 = b; mode = m; in_valid = 1'b1;
    acc = cyc;
    e.flags = model(a, b, m);
    e.lat   = model_lat(a, b);
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    rs1 = $urandom; rs2 = $urandom; mode = 3'($urandom);
    chk("busy_outputs_zero", 32'({in_ready, out_valid, flags_w}), 32'd0);
    t = 0;
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", 32'(out_valid), 32'd1);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk("latency", 32'(cyc - acc), 32'(e.lat));
    chk("flags", 32'(flags_w), 32'(e.flags));
    snap = flags_w;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      rs1 = $urandom; rs2 = $urandom; mode = 3'($urandom);
      @(negedge clk);
      chk("hold_stable", 32'({out_valid, flags_w}), 32'({1'b1, snap}));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_idle", 32'({in_ready, out_valid, flags_w}), 32'h100);
  endtask

  task automatic reset_mid_busy();
    int seen;
    @(negedge clk);
    rs1 = 32'h1234_5678; rs2 = 32'h1234_5678; mode = 3'b000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy3_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset_mid_busy", 32'({in_ready, out_valid, flags_w}), 32'h100);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_result_after_reset", 32'(seen), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    rs1 = '0; rs2 = '0; mode = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'({in_ready, out_valid, flags_w}), 32'h100);
    rst = 1'b0;

    run_op(32'd5, 32'd5, 3'b000, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 3'b100, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 3'b110, 0);
    run_op(32'h8000_0000, 32'd0, 3'b101, 0);
    run_op(32'h1234_5678, 32'h1234_5679, 3'b001, 5);
    run_op(32'd7, 32'h8000_0007, 3'b111, 0);
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 3'b010, 0);
    run_op(32'h0000_0010, 32'h0000_0001, 3'b011, 0);
    run_op(32'hABCD_0000, 32'hABCD_0000, 3'b001, 2);

    reset_mid_busy();

    for (int k = 0; k < 24; k++) begin
      a = $urandom;
      b = (k % 2 == 0) ? (a ^ (32'd1 << $urandom_range(31, 0))) : 32'($urandom);
      if (k % 7 == 0) b = a;
      run_op(a, b, 3'($urandom_range(7, 0)), k % 3);
    end

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
